// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// Circular in-order reorder buffer for the Qu processor. Rename allocates one
// entry per cycle at the tail, the CDB marks entries ready and records their
// results, and ready entries retire in program order from the head, driving
// the physical register file write and the busy-table clear.
//
// Tag 0 is reserved ("no producer") and is never allocated: both pointers
// skip from DEPTH-1 straight back to 1, so usable capacity is DEPTH-1.
//
// Optional feature: define QU_ROB_FLUSH_EN to add the `flush` input, which
// empties the buffer in one cycle. Without the macro there is no flush port
// and only reset empties the buffer.
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter  int DEPTH             = 16,
  parameter  int PHY_RF_ADDR_WIDTH = 6,
  localparam int ROB_AW            = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  // allocation (from rename)
  input  logic                         alloc_en,
  input  logic [PHY_RF_ADDR_WIDTH-1:0] alloc_dest,
  input  logic                         alloc_dest_valid,
  output logic [ROB_AW-1:0]            rob_tail_ptr,
  output logic                         rob_full,
  output logic                         rob_empty,
  // completion (common data bus)
  input  logic                         cdb_valid,
  input  logic [ROB_AW-1:0]            cdb_rob_addr,
  input  logic [31:0]                  cdb_data,
  // retirement
  output logic                         commit_valid,
  output logic [ROB_AW-1:0]            commit_rob_addr,
  output logic [PHY_RF_ADDR_WIDTH-1:0] commit_dest,
  output logic                         commit_dest_valid,
  output logic [31:0]                  commit_data
`ifdef QU_ROB_FLUSH_EN
  ,
  input  logic                         flush
`endif
);

  // One ROB entry.
  typedef struct packed {
    logic                         valid;
    logic                         ready;
    logic                         dest_valid;
    logic [PHY_RF_ADDR_WIDTH-1:0] dest;
    logic [31:0]                  data;
  } rob_entry_t;

  localparam logic [ROB_AW-1:0] TAG_FIRST = ROB_AW'(1);
  localparam logic [ROB_AW-1:0] TAG_LAST  = ROB_AW'(DEPTH - 1);

  rob_entry_t        r_rob [DEPTH];
  logic [ROB_AW-1:0] r_head;
  logic [ROB_AW-1:0] r_tail;
  logic [ROB_AW-1:0] r_count;   // 0 .. DEPTH-1 fits in ROB_AW bits

  logic              w_full;
  logic              w_empty;
  logic              w_flush;
  logic              w_alloc;
  logic              w_cdb_hit;
  logic              w_commit;
  rob_entry_t        w_head_entry;

  // Advance a tag, skipping the reserved tag 0 on wrap.
  function automatic logic [ROB_AW-1:0] f_next(input logic [ROB_AW-1:0] p);
    return (p == TAG_LAST) ? TAG_FIRST : p + ROB_AW'(1);
  endfunction

`ifdef QU_ROB_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_full       = (r_count == TAG_LAST);
  assign w_empty      = (r_count == '0);
  assign w_head_entry = r_rob[r_head];

  // A full buffer refuses allocation even if the head retires this cycle,
  // so the full flag never depends on the commit decision.
  assign w_alloc   = alloc_en && !w_full;

  // Completions to tag 0 or to a free entry are dropped.
  assign w_cdb_hit = cdb_valid && (cdb_rob_addr != '0) && r_rob[cdb_rob_addr].valid;

  // Retire only from registered state: no CDB-to-commit bypass.
  assign w_commit  = !w_empty && w_head_entry.valid && w_head_entry.ready && !w_flush;

  assign rob_tail_ptr = r_tail;
  assign rob_full     = w_full;
  assign rob_empty    = w_empty;

  // Commit outputs are held at zero whenever nothing retires.
  always_comb begin
    // NOTE: every output gets a default before any condition, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    commit_valid      = 1'b0;
    commit_rob_addr   = '0;
    commit_dest       = '0;
    commit_dest_valid = 1'b0;
    commit_data       = '0;
    if (w_commit) begin
      commit_valid      = 1'b1;
      commit_rob_addr   = r_head;
      commit_dest       = w_head_entry.dest;
      commit_dest_valid = w_head_entry.dest_valid;
      commit_data       = w_head_entry.data;
    end
  end

  // Entry array, pointers and occupancy: completion, retirement and allocation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the entry array is reset too, because a reset must discard
      // every in-flight entry at once; stale valid bits would otherwise let
      // CDB writes and commits act on dead uops.
      for (int i = 0; i < DEPTH; i++) begin
        r_rob[i] <= '0;
      end
      r_head  <= TAG_FIRST;
      r_tail  <= TAG_FIRST;
      r_count <= '0;
    end else if (w_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rob[i] <= '0;
      end
      r_head  <= TAG_FIRST;
      r_tail  <= TAG_FIRST;
      r_count <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; where several updates hit
      // the same entry in one cycle the last one written below wins, which
      // gives the ordering completion < retirement < allocation.
      if (w_cdb_hit) begin
        r_rob[cdb_rob_addr].ready <= 1'b1;
        r_rob[cdb_rob_addr].data  <= cdb_data;
      end

      if (w_commit) begin
        r_rob[r_head].valid <= 1'b0;
        r_rob[r_head].ready <= 1'b0;
        r_head              <= f_next(r_head);
      end

      if (w_alloc) begin
        r_rob[r_tail].valid      <= 1'b1;
        r_rob[r_tail].ready      <= 1'b0;
        r_rob[r_tail].dest_valid <= alloc_dest_valid;
        r_rob[r_tail].dest       <= alloc_dest;
        r_rob[r_tail].data       <= '0;
        r_tail                   <= f_next(r_tail);
      end

      unique case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + ROB_AW'(1);
        2'b01:   r_count <= r_count - ROB_AW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
